wb_host_master: RTL

Wishbone classic single-transfer master that drives the crypto core's Wishbone slave port (address, data, select, write enable; ack and read data back) from a buffered command stream. It sits between a local command source (test sequencer, LA-driven controller or on-chip CPU shim) and `cryptotop`. It serialises queued read and write commands into Wishbone cycles and returns one response per command. An optional watchdog aborts cycles that are never acknowledged.

---
 rtl/wbm_pkg.sv | 23 ++
 rtl/wbm_cmd_fifo.sv | 49 ++++
 rtl/wb_host_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/wbm_pkg.sv
// Shared types for the Wishbone host master.
//   wbm_state_e : master FSM states
//   wbm_cmd_t   : one queued command {we, adr, dat, sel}, 69 bits
//   WBM_TIMEOUT_DEFAULT : default watchdog limit in REQ cycles
package wbm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } wbm_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wbm_cmd_t;

  localparam int WBM_CMD_W           = $bits(wbm_cmd_t);
  localparam int WBM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wbm_cmd_fifo.sv
// Synchronous show-ahead FIFO for queued Wishbone commands.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate occupancy counter.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write one entry (ignored while full)
//   full              : no room left
//   pop, pop_data     : pop_data always shows the oldest entry; pop advances
//   empty             : no entries stored
module wbm_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master. Buffers read/write commands in a
// small FIFO, runs them one at a time on the Wishbone port and returns one
// response per command, in command order.
//
// Optional feature macro: WBM_TIMEOUT_EN -- when defined, a cycle left
// unacknowledged for TIMEOUT_CYCLES strobe cycles is aborted and answered
// with rsp_err_o = 1. When undefined, REQ waits forever and rsp_err_o = 0.
//
// Ports:
//   wb_clk_i, wb_rst_i       : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o  : command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i : command payload
//   rsp_valid_o/rsp_ready_i  : response handshake
//   rsp_dat_o, rsp_err_o     : read data (0 for writes/aborts), abort flag
//   wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o : Wishbone request
//   wbm_ack_i, wbm_dat_i     : Wishbone acknowledge and read data
//   busy_o                   : FSM not IDLE or commands still queued
//
// state | meaning
// IDLE  | no cycle on the bus; pops the next command when one is queued
// REQ   | cyc/stb high, request held stable until ack (or watchdog abort)
// RSP   | response held on rsp_* until the consumer takes it
module wb_host_master
  import wbm_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = WBM_TIMEOUT_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o
);

  wbm_state_e state;
  wbm_state_e state_nxt;

  wbm_cmd_t cmd_in;
  wbm_cmd_t fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     ack_req;
  logic     timeout_hit;

  assign cmd_in      = {cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};
  assign fifo_push   = cmd_valid_i && !fifo_full;
  assign cmd_ready_o = !fifo_full;

  wbm_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (WBM_CMD_W)
  ) u_cmd_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (fifo_push),
    .push_data (cmd_in),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty)
  );

  // Ack only means something while a request is on the bus.
  assign ack_req = (state == REQ) && wbm_ack_i;

`ifdef WBM_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       rsp_err_q;

  // Held at zero outside REQ, so it starts from 0 on every REQ entry.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)           to_cnt <= '0;
    else if (state != REQ)  to_cnt <= '0;
    else if (!wbm_ack_i)    to_cnt <= to_cnt + 8'd1;
  end

  // Fires in the last allowed strobe cycle; a simultaneous ack takes priority.
  assign timeout_hit = (state == REQ) && !wbm_ack_i &&
                       (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)         rsp_err_q <= 1'b0;
    else if (ack_req)     rsp_err_q <= 1'b0;
    else if (timeout_hit) rsp_err_q <= 1'b1;
  end

  assign rsp_err_o = rsp_err_q;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign rsp_err_o      = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty)             state_nxt = REQ;
      REQ:     if (ack_req || timeout_hit)  state_nxt = RSP;
      RSP:     if (rsp_ready_i)             state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    wbm_cyc_o   = (state == REQ);
    wbm_stb_o   = (state == REQ);
    rsp_valid_o = (state == RSP);
    fifo_pop    = (state == IDLE) && !fifo_empty;
    busy_o      = (state != IDLE) || !fifo_empty;
  end

  // Request and response data registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_dat_o <= '0;
    end else begin
      if (fifo_pop) begin
        wbm_we_o  <= fifo_head.we;
        wbm_sel_o <= fifo_head.sel;
        wbm_adr_o <= fifo_head.adr;
        wbm_dat_o <= fifo_head.dat;
      end
      if (ack_req)          rsp_dat_o <= wbm_we_o ? 32'h0 : wbm_dat_i;
      else if (timeout_hit) rsp_dat_o <= 32'h0;
    end
  end

endmodule
